// File: rtl/regfile_irq_flush.sv
// rtl/regfile_irq_flush.sv - register file with sticky interrupt-cause bits and a sequential flush engine
// Ports: clk/reset (sync, active-high); addr1/data1 and addr2/data2 combinational read ports;
//        wr/addr3/data3 synchronous write port; irq_set sets sticky bits of entry IRQ_REG;
//        flush_req starts a one-entry-per-cycle clear, busy high while clearing;
//        irq_pending is the OR of the cause bits.
// Optional: REGFILE_BYPASS_EN forwards the same-cycle write data to matching read ports.
module regfile_irq_flush #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int IRQ_REG = 27,
    parameter int IRQ_N   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr1,
    output logic [DATA_W-1:0] data1,
    input  logic [ADDR_W-1:0] addr2,
    output logic [DATA_W-1:0] data2,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr3,
    input  logic [DATA_W-1:0] data3,
    input  logic [IRQ_N-1:0]  irq_set,
    input  logic              flush_req,
    output logic              busy,
    output logic              irq_pending
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_next;
    logic [DATA_W-1:0] regs      [DEPTH];
    logic [DATA_W-1:0] regs_next [DEPTH];
    logic [DATA_W-1:0] irq_ext;
    logic              wr_ok;

    // Built by assignment rather than replication so IRQ_N == DATA_W stays legal.
    always_comb begin
        irq_ext            = '0;
        irq_ext[IRQ_N-1:0] = irq_set;
    end

    // Writes are only honoured while the flush engine is idle.
    assign wr_ok = (state == IDLE) && wr && (addr3 != '0);

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (flush_req) begin
                    state_next = CLEAR;
                    ptr_next   = ADDR_W'(1);
                end
            end
            CLEAR: begin
                // Terminal compare ends the flush on the last index; the pointer never wraps.
                if (ptr == LAST_IDX) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr + ADDR_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                ptr_next   = '0;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_next[i] = regs[i];
        end
        if (wr_ok) begin
            regs_next[addr3] = data3;
        end
        if (state == CLEAR) begin
            regs_next[ptr] = '0;
        end
        // Interrupt sets are applied last so they win over both a write and a clear.
        regs_next[IRQ_REG] = regs_next[IRQ_REG] | irq_ext;
        regs_next[0]       = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            state <= IDLE;
            ptr   <= '0;
        end else begin
            regs  <= regs_next;
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic [DATA_W-1:0] wr_val;

    // Forwarded value must match what the entry will hold after the edge.
    assign wr_val = data3 | ((addr3 == ADDR_W'(IRQ_REG)) ? irq_ext : '0);

    always_comb begin
        data1 = (addr1 == '0) ? '0 : regs[addr1];
        data2 = (addr2 == '0) ? '0 : regs[addr2];
        if (wr_ok && (addr1 == addr3)) begin
            data1 = wr_val;
        end
        if (wr_ok && (addr2 == addr3)) begin
            data2 = wr_val;
        end
    end
`else
    always_comb begin
        data1 = (addr1 == '0) ? '0 : regs[addr1];
        data2 = (addr2 == '0) ? '0 : regs[addr2];
    end
`endif

    assign busy        = (state == CLEAR);
    assign irq_pending = |regs[IRQ_REG][IRQ_N-1:0];

endmodule

// File: tb/tb_regfile_irq_flush.sv
// tb/tb_regfile_irq_flush.sv - randomized self-checking bench for regfile_irq_flush
module tb_regfile_irq_flush;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  addr1;
    logic [4:0]  addr2;
    logic [4:0]  addr3;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] data3;
    logic        wr;
    logic [3:0]  irq_set;
    logic        flush_req;
    logic        busy;
    logic        irq_pending;

    regfile_irq_flush dut (
        .clk         (clk),
        .reset       (reset),
        .addr1       (addr1),
        .data1       (data1),
        .addr2       (addr2),
        .data2       (data2),
        .wr          (wr),
        .addr3       (addr3),
        .data3       (data3),
        .irq_set     (irq_set),
        .flush_req   (flush_req),
        .busy        (busy),
        .irq_pending (irq_pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: plain array of contents plus the index the flush will clear next (0 = not flushing).
    logic [31:0] mdl [32];
    int          flush_pos;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        logic [31:0] v;
        v = (a == 5'd0) ? 32'd0 : mdl[a];
`ifdef REGFILE_BYPASS_EN
        if (flush_pos == 0 && wr && addr3 != 5'd0 && a == addr3)
            v = data3 | ((addr3 == 5'd27) ? {28'd0, irq_set} : 32'd0);
`endif
        return v;
    endfunction

    task automatic cyc(input logic r, input logic w, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] a3, input logic [31:0] d, input logic [3:0] irq,
                       input logic fl);
        reset = r; wr = w; addr1 = a1; addr2 = a2; addr3 = a3; data3 = d;
        irq_set = irq; flush_req = fl;
        #1;
        check("data1", data1, exp_read(a1));
        check("data2", data2, exp_read(a2));
        check("busy", {31'd0, busy}, 32'(flush_pos != 0));
        check("irq_pending", {31'd0, irq_pending}, 32'(mdl[27][3:0] != 4'd0));
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
            flush_pos = 0;
        end else begin
            if (flush_pos != 0) begin
                mdl[flush_pos] = 32'd0;
                flush_pos = (flush_pos == 31) ? 0 : flush_pos + 1;
            end else begin
                if (w && a3 != 5'd0) mdl[a3] = d;
                if (fl) flush_pos = 1;
            end
            mdl[27] = mdl[27] | {28'd0, irq};
        end
        #1;
    endtask

    initial begin
        int n;
        reset = 1'b1; wr = 1'b0; addr1 = '0; addr2 = '0; addr3 = '0; data3 = '0;
        irq_set = '0; flush_req = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        flush_pos = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state: every entry reads zero.
        for (int i = 0; i < 32; i++) cyc(0, 0, 5'(i), 5'(31 - i), 0, 0, 0, 0);

        // Basic write/read and r0 hardwired.
        cyc(0, 1, 0, 0, 5, 32'hDEADBEEF, 0, 0);
        cyc(0, 0, 5, 0, 0, 0, 0, 0);
        check("r5_read", data1, 32'hDEADBEEF);
        check("r0_read", data2, 32'd0);
        cyc(0, 1, 0, 0, 0, 32'hFFFFFFFF, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("r0_after_write", data1, 32'd0);

        // Sticky interrupt bit and software clear.
        cyc(0, 0, 27, 0, 0, 0, 4'b0010, 0);
        check("irq_bit", data1, 32'h2);
        check("irq_pending_set", {31'd0, irq_pending}, 32'd1);
        cyc(0, 1, 27, 0, 27, 0, 0, 0);
        check("irq_pending_clr", {31'd0, irq_pending}, 32'd0);

        // Interrupt set and write in the same cycle.
        cyc(0, 1, 27, 0, 27, 32'h100, 4'b0001, 0);
        cyc(0, 0, 27, 0, 0, 0, 0, 0);
        check("irq_vs_write", data1, 32'h101);
        cyc(0, 1, 0, 0, 27, 0, 0, 0);

        // Full flush: duration, ordering, dropped write.
        for (int i = 1; i < 32; i++) cyc(0, 1, 0, 0, 5'(i), 32'(i), 0, 0);
        cyc(0, 0, 1, 31, 0, 0, 0, 1);
        n = 0;
        while (busy && n < 100) begin
            cyc(0, n == 5, 1, 31, 3, 32'hBAD0BAD0, 0, 0);
            if (n == 0) begin
                check("r1_cleared_first", data1, 32'd0);
                check("r31_not_yet", data2, 32'd31);
            end
            n++;
        end
        check("busy_cycles", 32'(n), 32'd31);
        cyc(0, 0, 3, 31, 0, 0, 0, 0);
        check("r3_write_dropped", data1, 32'd0);
        for (int i = 0; i < 32; i++) cyc(0, 0, 5'(i), 5'(i), 0, 0, 0, 0);

        // Reset in the middle of a flush.
        for (int i = 1; i < 32; i++) cyc(0, 1, 0, 0, 5'(i), $urandom, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) cyc(0, 0, 5'($urandom), 5'($urandom), 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        check("busy_after_reset", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 32; i++) cyc(0, 0, 5'(i), 5'(31 - i), 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        check("flush_after_reset", {31'd0, busy}, 32'd1);
        n = 0;
        while (busy && n < 100) begin
            cyc(0, 0, 5'($urandom), 5'($urandom), 0, 0, 0, 0);
            n++;
        end
        check("flush2_cycles", 32'(n), 32'd31);

        // Same-cycle write/read of r7.
        cyc(0, 1, 0, 0, 7, 32'h11111111, 0, 0);
        wr = 1'b1; addr3 = 5'd7; data3 = 32'h12345678; addr1 = 5'd7; addr2 = 5'd0;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_r7", data1, 32'h12345678);
`else
        check("bypass_r7", data1, 32'h11111111);
`endif
        cyc(0, 1, 7, 0, 7, 32'h12345678, 0, 0);

        // Randomized traffic against the reference.
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] a3;
            a3 = ($urandom_range(0, 3) == 0) ? 5'd27 : 5'($urandom);
            cyc($urandom_range(0, 63) == 0, 1'($urandom), 5'($urandom), 5'($urandom), a3,
                $urandom, ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0,
                $urandom_range(0, 31) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
